// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the regfile write port between WB (priority) and a buffered LU queue.
// Define REGFILE_WPORT_AGE_EN to stall WB once the LU head has waited AGE_MAX cycles.
module regfile_wport_arbiter #(
    parameter int DEPTH   = 2,
    parameter int AGE_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic [31:0] wb_rd_wdata_i,
    output logic        wb_stall_o,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_rd_addr_i,
    input  logic [31:0] lu_rd_wdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_rd_wdata_o,
    output logic [31:0] lu_pending_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             out_lu;
    logic             push, pop, wb_grant;
    logic [31:0]      pend;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness comes from the registered count only, so a pop never frees a slot for a same-cycle push.
    assign lu_ready_o = count < CW'(DEPTH);
    assign push       = lu_valid_i & lu_ready_o & (lu_rd_addr_i != 5'd0);
    assign wb_grant   = wb_we_i & (wb_rd_addr_i != 5'd0) & ~wb_stall_o;
    assign pop        = ~wb_grant & (count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (pop) vld[rd_ptr] <= 1'b0;
            if (push) vld[wr_ptr] <= 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_rd_addr_i;
            fifo_data[wr_ptr] <= lu_rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_we_o       <= 1'b0;
            rf_rd_addr_o  <= '0;
            rf_rd_wdata_o <= '0;
            out_lu        <= 1'b0;
        end else begin
            rf_we_o <= wb_grant | pop;
            out_lu  <= pop;
            if (wb_grant) begin
                rf_rd_addr_o  <= wb_rd_addr_i;
                rf_rd_wdata_o <= wb_rd_wdata_i;
            end else if (pop) begin
                rf_rd_addr_o  <= fifo_addr[rd_ptr];
                rf_rd_wdata_o <= fifo_data[rd_ptr];
            end
        end
    end

    // An LU write stays visible as pending until it has actually landed in the regfile.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) pend[fifo_addr[i]] = 1'b1;
        if (rf_we_o & out_lu) pend[rf_rd_addr_o] = 1'b1;
    end

    assign lu_pending_o = {pend[31:1], 1'b0};

`ifdef REGFILE_WPORT_AGE_EN
    localparam int AW = $clog2(AGE_MAX + 1);
    logic [AW-1:0] age;

    assign wb_stall_o = (count != '0) & (age == AW'(AGE_MAX));

    // Whenever the queue is non-empty and nothing pops, WB took the port from the head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) age <= '0;
        else age <= (pop | (count == '0)) ? '0 : age + 1'b1;
    end
`else
    assign wb_stall_o = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: randomized + directed bench with a queue-based reference model and a write scoreboard.
module tb_regfile_wport_arbiter;
    localparam int DEPTH   = 2;
    localparam int AGE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_rd_addr_i = '0;
    logic [31:0] wb_rd_wdata_i = '0;
    logic        wb_stall_o;
    logic        lu_valid_i = 1'b0;
    logic        lu_ready_o;
    logic [4:0]  lu_rd_addr_i = '0;
    logic [31:0] lu_rd_wdata_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_wdata_o;
    logic [31:0] lu_pending_o;

    always #5 clk = ~clk;

    regfile_wport_arbiter #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_we_i(wb_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wdata_i(wb_rd_wdata_i),
        .wb_stall_o(wb_stall_o),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
        .lu_rd_addr_i(lu_rd_addr_i), .lu_rd_wdata_i(lu_rd_wdata_i),
        .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_wdata_o(rf_rd_wdata_o),
        .lu_pending_o(lu_pending_o)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         mq[$];
    wr_t         exp_q[$];
    int          waits = 0;
    logic        lo_we = 1'b0, lo_lu = 1'b0;
    logic [4:0]  lo_a = '0;
    bit          wb_taken = 1'b0, lu_taken = 1'b0;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mpend();
        logic [31:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (lo_we && lo_lu) p[lo_a] = 1'b1;
        return p;
    endfunction

    // Reference model: decides each cycle's winner from the queue/age rules and predicts the write.
    always @(negedge clk) begin : model
        bit  rdy, stall_m, wbreq, wbg;
        wr_t e;
        if (!rst_i) begin
            rdy = mq.size() < DEPTH;
`ifdef REGFILE_WPORT_AGE_EN
            stall_m = mq.size() > 0 && waits == AGE_MAX;
`else
            stall_m = 1'b0;
`endif
            chk("lu_ready", 32'(lu_ready_o), 32'(rdy));
            chk("wb_stall", 32'(wb_stall_o), 32'(stall_m));
            chk("lu_pending", lu_pending_o, mpend());
            chk("rf_we", 32'(rf_we_o), 32'(lo_we));
            assert (!(wb_we_i && wb_rd_addr_i != 5'd0 && lu_pending_o[wb_rd_addr_i]))
                else $error("WB requested a register with a queued LU write");
            wbreq = wb_we_i && wb_rd_addr_i != 5'd0;
            wbg   = wbreq && !stall_m;
            if (wbg) begin
                e.a = wb_rd_addr_i;
                e.d = wb_rd_wdata_i;
                exp_q.push_back(e);
                lo_we = 1'b1; lo_lu = 1'b0; lo_a = e.a;
                waits = (mq.size() > 0) ? waits + 1 : 0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_q.push_back(e);
                lo_we = 1'b1; lo_lu = 1'b1; lo_a = e.a;
                waits = 0;
            end else begin
                lo_we = 1'b0; lo_lu = 1'b0;
                waits = 0;
            end
            if (lu_valid_i && rdy && lu_rd_addr_i != 5'd0) begin
                e.a = lu_rd_addr_i;
                e.d = lu_rd_wdata_i;
                mq.push_back(e);
            end
            wb_taken = !(wbreq && !wbg);
            lu_taken = rdy;
        end
    end

    // Scoreboard monitor: every regfile write must match the oldest predicted write.
    always @(posedge clk) begin : monitor
        wr_t e;
        #1;
        if (!rst_i && rf_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write at %0t",
                         rf_rd_addr_o, rf_rd_wdata_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_rd_addr_o), 32'(e.a));
                chk("wr_data", rf_rd_wdata_o, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
        if (wb_taken) wb_we_i = 1'b0;
        if (lu_taken) lu_valid_i = 1'b0;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
        wb_we_i = 1'b1; wb_rd_addr_i = a; wb_rd_wdata_i = d;
    endtask

    task automatic set_lu(input logic [4:0] a, input logic [31:0] d);
        lu_valid_i = 1'b1; lu_rd_addr_i = a; lu_rd_wdata_i = d;
    endtask

    initial begin
        int first;
        #12;
        chk("reset_rf_we", 32'(rf_we_o), 32'd0);
        chk("reset_rf_addr", 32'(rf_rd_addr_o), 32'd0);
        chk("reset_rf_data", rf_rd_wdata_o, 32'd0);
        chk("reset_pending", lu_pending_o, 32'd0);
        chk("reset_stall", 32'(wb_stall_o), 32'd0);
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        chk("ready_after_reset", 32'(lu_ready_o), 32'd1);

        set_wb(5'd5, 32'hDEADBEEF);
        tick();
        chk("lone_wb_we", 32'(rf_we_o), 32'd1);
        chk("lone_wb_addr", 32'(rf_rd_addr_o), 32'd5);
        chk("lone_wb_data", rf_rd_wdata_o, 32'hDEADBEEF);
        tick();
        chk("lone_wb_we_off", 32'(rf_we_o), 32'd0);

        set_lu(5'd7, 32'h1234);
        tick();
        chk("lone_lu_pending_t1", lu_pending_o, 32'h80);
        chk("lone_lu_we_t1", 32'(rf_we_o), 32'd0);
        tick();
        chk("lone_lu_we_t2", 32'(rf_we_o), 32'd1);
        chk("lone_lu_addr_t2", 32'(rf_rd_addr_o), 32'd7);
        chk("lone_lu_pending_t2", lu_pending_o, 32'h80);
        tick();
        chk("lone_lu_pending_t3", lu_pending_o, 32'd0);

        set_wb(5'd0, 32'h55);
        tick();
        chk("wb_x0_no_write", 32'(rf_we_o), 32'd0);
        set_lu(5'd0, 32'h66);
        tick();
        chk("lu_x0_no_pending", lu_pending_o, 32'd0);
        chk("lu_x0_accepted", 32'(lu_valid_i), 32'd0);
        tick();
        chk("lu_x0_no_write", 32'(rf_we_o), 32'd0);

        set_wb(5'd10, 32'hA); set_lu(5'd3, 32'h33);
        tick();
        set_wb(5'd11, 32'hB); set_lu(5'd4, 32'h44);
        tick();
        chk("full_ready_low", 32'(lu_ready_o), 32'd0);
        set_wb(5'd12, 32'hC); set_lu(5'd5, 32'h55);
        tick();
        chk("full_third_held", 32'(lu_valid_i), 32'd1);
        chk("full_ready_still_low", 32'(lu_ready_o), 32'd0);
        tick();
        chk("drain_first", 32'(rf_rd_addr_o), 32'd3);
        tick();
        chk("drain_second", 32'(rf_rd_addr_o), 32'd4);
        repeat (4) tick();

`ifdef REGFILE_WPORT_AGE_EN
        set_lu(5'd20, 32'h2020);
        tick();
        first = -1;
        for (int k = 0; k < 12; k++) begin
            if (!wb_we_i) set_wb(5'(k % 9 + 1), 32'(k));
            if (wb_stall_o && first < 0) first = k;
            tick();
        end
        chk("age_stall_cycle", 32'(first), 32'd8);
        repeat (4) tick();
`endif

        set_wb(5'd13, 32'hD); set_lu(5'd21, 32'h21);
        tick();
        set_wb(5'd14, 32'hE); set_lu(5'd22, 32'h22);
        tick();
        #1;
        rst_i = 1'b1;
        #1;
        chk("midreset_rf_we", 32'(rf_we_o), 32'd0);
        chk("midreset_pending", lu_pending_o, 32'd0);
        chk("midreset_stall", 32'(wb_stall_o), 32'd0);
        mq.delete(); exp_q.delete();
        waits = 0; lo_we = 1'b0; lo_lu = 1'b0;
        wb_we_i = 1'b0; lu_valid_i = 1'b0;
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        chk("midreset_ready", 32'(lu_ready_o), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            if (!wb_we_i && $urandom_range(0, 1) == 1)
                set_wb(($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 15)), $urandom);
            if (!lu_valid_i && $urandom_range(0, 2) == 0)
                set_lu(($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(16, 31)), $urandom);
            tick();
        end
        repeat (40) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_pending", lu_pending_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between the WB stage (primary) and a long-latency unit (LU: divider/CSR/debug writeback, secondary).
- LU writes are buffered in a small in-order FIFO; a registered output stage drives the regfile write port.
- Exports a pending-rd mask so the issue/ID logic can stall on registers with queued LU writes.
- Sits between WB/LU and the regfile write inputs (we/addr/wdata).

Parameters:
- DEPTH, 2, LU FIFO entries (integer >= 1, any value, not restricted to powers of two)
- AGE_MAX, 8, consecutive LU-head wait cycles before WB is stalled (used only with the optional feature; >= 1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- wb_we_i  in  1  WB-stage write request; no handshake, single cycle
- wb_rd_addr_i  in  5  WB destination register
- wb_rd_wdata_i  in  32  WB write data
- wb_stall_o  out  1  WB must hold its request this cycle (combinational)
- lu_valid_i  in  1  LU write request valid
- lu_ready_o  out  1  FIFO can accept an LU request
- lu_rd_addr_i  in  5  LU destination register
- lu_rd_wdata_i  in  32  LU write data
- rf_we_o  out  1  regfile write enable (registered)
- rf_rd_addr_o  out  5  regfile write address (registered)
- rf_rd_wdata_o  out  32  regfile write data (registered)
- lu_pending_o  out  32  bit n = a queued or in-flight LU write targets xn

Behaviour:
- Reset (async, any cycle): FIFO emptied, contents dropped.
  - rf_we_o=0, rf_rd_addr_o=0, rf_rd_wdata_o=0.
  - lu_pending_o=0, age counter=0, wb_stall_o=0.
  - lu_ready_o=1 once reset deasserts.
- LU accept: lu_valid_i & lu_ready_o at a rising edge.
  - lu_ready_o = (count < DEPTH), from the registered count only.
  - No same-cycle pass-through: a pop does not free space for a push in that cycle.
  - An accepted LU request with addr 0 is consumed and discarded (never enqueued).
- Grant, evaluated each cycle:
  - WB wins if wb_we_i=1, wb_rd_addr_i!=0 and wb_stall_o=0.
  - Otherwise, if the FIFO is non-empty, the head is popped.
  - A WB write to x0 counts as no request.
- Output stage: the winner's addr/data register into rf_* at the next edge, with rf_we_o=1; with no winner, rf_we_o=0 and addr/data hold.
- Latency:
  - WB request at cycle t -> rf_we_o=1 at t+1.
  - LU accepted at t into an empty FIFO -> head at t+1 -> rf_we_o=1 at t+2 at the earliest.
- FIFO: strict in-order; simultaneous push and pop permitted when 0 < count < DEPTH; count unchanged.
- lu_pending_o is the OR of one-hot(addr) over:
  - all valid FIFO entries, and
  - the output stage while rf_we_o=1 and the stage holds an LU write.
  - Bits fall in the cycle after the write reaches the regfile.
  - Bit 0 is always 0.
- Ordering precondition, enforced by issue logic and checked by a bench assertion: WB never requests an rd whose lu_pending_o bit is set. The arbiter does not reorder for WAW.
- Without the optional feature: wb_stall_o is constant 0; LU may starve indefinitely under back-to-back WB writes.

Optional Feature:
- Macro: REGFILE_WPORT_AGE_EN.
- When defined, the age counter ($clog2(AGE_MAX+1) bits):
  - increments each cycle the FIFO is non-empty and the head loses to WB;
  - clears on any head pop or when the FIFO is empty.
- When age == AGE_MAX:
  - wb_stall_o=1 (combinational);
  - the head is granted that cycle;
  - the counter clears at the next edge.
- A stalled WB request must be held by the pipeline; it is granted in a later cycle.
- When undefined: no counter is instantiated and wb_stall_o is tied to 0.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, assert rst_i asynchronously -> rf_we_o, lu_pending_o and wb_stall_o are 0 immediately; lu_ready_o=1 after release; dropped entries are never written.
- Lone WB: wb_we_i=1, addr 5, data 0xDEADBEEF at t -> rf_we_o=1, addr 5, data 0xDEADBEEF at t+1; rf_we_o=0 at t+2.
- Lone LU: accept addr 7, data 0x1234 at t -> lu_pending_o=0x80 from t+1; rf write at t+2; lu_pending_o=0 at t+3.
- Full FIFO (DEPTH=2): push 2 LU entries while WB writes every cycle -> lu_ready_o=0, third request held; entries drain in order (addr 3 then 4) once WB idles.
- Aging (macro on, AGE_MAX=8): continuous WB writes with a queued LU entry -> wb_stall_o=1 on the 9th cycle, LU head written next edge, held WB written the cycle after.
- x0 handling: WB write to x0 -> rf_we_o stays 0; LU request to x0 -> accepted, no pending bit, no regfile write.
